arb_mux_nx1: RTL
================

// Module: arb_mux_nx1
//
// PURPOSE
//   Registered N:1 channel multiplexer with per-channel valid/ready handshakes.
//   It generalises the 2:1 combinational data mux to NUM_CH inputs, with two
//   selection modes: external select or internal round-robin arbitration.
//   It sits between datapath producers and a single shared consumer (FU or
//   register) in the generated HLS datapath.
//   The output is a one-entry register stage, so the block can sustain one
//   transfer per cycle.
//
// PARAMETERS
//   DATAWIDTH  64  width of each data channel, in bits
//   NUM_CH     4   number of input channels; must be >= 2
//   SELW       2   select/channel-index width; must equal ceil(log2(NUM_CH))
//   MODE       0   0 = fixed (channel chosen by sel); 1 = round-robin
//
// PORTS
//   Clk      in   1                   clock; all state updates on rising edge
//   Rst      in   1                   synchronous reset, active-high
//   a        in   NUM_CH*DATAWIDTH    packed inputs; channel k = a[k*DATAWIDTH +: DATAWIDTH]
//   a_valid  in   NUM_CH              per-channel data-valid
//   a_ready  out  NUM_CH              per-channel accept; at most one bit high
//   sel      in   SELW                channel select; used only when MODE=0
//   d        out  DATAWIDTH           registered output data
//   d_valid  out  1                   d holds valid data
//   d_ready  in   1                   consumer accepts d this cycle
//   d_ch     out  SELW                index of the source channel of d
//
// BEHAVIOUR
//   - Reset (Rst=1 at a rising edge):
//       d=0, d_valid=0, d_ch=0, last_grant=NUM_CH-1.
//       a_ready is forced to 0 while Rst=1.
//       Any held output is discarded; reset mid-transfer loses that word.
//   - slot_free = !d_valid || d_ready.
//   - Grant is combinational and resolved in the same cycle:
//       MODE=0: grant channel sel if sel<NUM_CH and a_valid[sel]=1.
//               sel>=NUM_CH gives no grant.
//       MODE=1: first k with a_valid[k]=1, searching from (last_grant+1)
//               mod NUM_CH upward and wrapping.
//   - Load: load = slot_free && grant exists && !Rst.
//       a_ready[g] = load; all other a_ready bits are 0.
//       a_ready depends on a_valid; the handshake is valid-before-ready.
//   - On load, at the rising edge: d<=channel g data, d_ch<=g, d_valid<=1.
//       In MODE=1, last_grant<=g.
//   - No load and d_ready=1: d_valid<=0.
//       d and d_ch hold their last values.
//   - No load and d_ready=0: d, d_ch and d_valid hold (stall).
//   - Latency: 1 cycle, from the input transfer to d_valid.
//       Throughput is 1 word/cycle with d_ready held high.
//   - last_grant changes only on a transfer. Stalls do not advance it.
//       Idle cycles do not advance it.
//   - In MODE=1, no channel waits more than NUM_CH-1 transfers once valid.
//   - Inputs must hold a and a_valid until a_ready; the block does not
//     check this.
//   - Simultaneous d_ready=1 and load: the old d is consumed and the new
//     word is captured in the same edge, with no bubble.
//
// TESTING
//   1. Reset, MODE=0, NUM_CH=4.
//      Hold Rst=1 for 2 cycles -> d=0, d_valid=0, d_ch=0, a_ready=0000.
//   2. MODE=0, sel=2, a_valid=0100, ch2=64'hA5, d_ready=1
//      -> a_ready=0100 in that cycle; next cycle d=64'hA5, d_ch=2, d_valid=1.
//   3. MODE=0, sel=1, a_valid=0100 -> a_ready=0000, d_valid stays 0.
//      Set sel=3'd5 on a 3-bit SELW build with NUM_CH=5 -> no grant.
//   4. MODE=1, a_valid=1111 held, d_ready=1 for 8 cycles
//      -> d_ch sequence 0,1,2,3,0,1,2,3, with one transfer per cycle.
//   5. MODE=1, d_valid=1, d_ready=0 for 3 cycles, a_valid=1111
//      -> d, d_ch and last_grant unchanged, a_ready=0000.
//      Release d_ready -> grant goes to the next channel after the held d_ch.
//   6. Assert Rst while d_valid=1 and d_ready=0
//      -> next cycle d_valid=0, d=0.
//      After Rst drops, MODE=1 first grant goes to ch0.

Source files
------------

// File: rtl/arb_mux_nx1_if.sv
// Bus bundle for the N:1 registered channel mux: N producer channels in, one consumer out.
// Handshakes: a word moves on a channel when its valid and ready are both high at a rising
// Clk edge. Valid must not wait for ready. Ready may depend on valid in the same cycle.
interface arb_mux_nx1_if #(
  parameter int DATAWIDTH = 64,
  parameter int NUM_CH    = 4,
  parameter int SELW      = 2
);
  logic [NUM_CH*DATAWIDTH-1:0] a;
  logic [NUM_CH-1:0]           a_valid;
  logic [NUM_CH-1:0]           a_ready;
  logic [SELW-1:0]             sel;
  logic [DATAWIDTH-1:0]        d;
  logic                        d_valid;
  logic                        d_ready;
  logic [SELW-1:0]             d_ch;

  modport master (
    output a, a_valid, sel, d_ready,
    input  a_ready, d, d_valid, d_ch
  );

  modport slave (
    input  a, a_valid, sel, d_ready,
    output a_ready, d, d_valid, d_ch
  );
endinterface

// File: rtl/arb_mux_nx1.sv
// Registered N:1 channel mux with a one-entry output stage. The source is chosen either
// by an external select or by a round-robin arbiter. It sustains one transfer per cycle.
module arb_mux_nx1 #(
  parameter int DATAWIDTH = 64,
  parameter int NUM_CH    = 4,
  parameter int SELW      = 2,
  parameter int MODE      = 0
) (
  input logic           Clk,
  input logic           Rst,
  arb_mux_nx1_if.slave  bus
);

  logic [DATAWIDTH-1:0] d_q;
  logic                 d_valid_q;
  logic [SELW-1:0]      d_ch_q;
  logic [SELW-1:0]      last_grant;

  logic                 slot_free;
  logic                 grant_found;
  logic [SELW-1:0]      grant_idx;
  logic [DATAWIDTH-1:0] grant_data;
  logic                 load;
  int                   last_grant_i;

  assign slot_free    = !d_valid_q || bus.d_ready;
  assign last_grant_i = int'(last_grant);

  // Round-robin search walks offsets 1..NUM_CH from last_grant. The first valid channel wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    if (MODE == 0) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (bus.sel == SELW'(k) && bus.a_valid[k]) begin
          grant_found = 1'b1;
          grant_idx   = SELW'(k);
        end
      end
    end else begin
      for (int i = 1; i <= NUM_CH; i++) begin
        for (int k = 0; k < NUM_CH; k++) begin
          if (!grant_found && k == (last_grant_i + i) % NUM_CH && bus.a_valid[k]) begin
            grant_found = 1'b1;
            grant_idx   = SELW'(k);
          end
        end
      end
    end
  end

  always_comb begin
    grant_data = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (grant_idx == SELW'(k)) begin
        grant_data = bus.a[k*DATAWIDTH +: DATAWIDTH];
      end
    end
  end

  assign load = slot_free && grant_found && !Rst;

  always_comb begin
    bus.a_ready = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      bus.a_ready[k] = load && (grant_idx == SELW'(k));
    end
  end

  // A load and a consume in the same edge simply overwrite the register, so no bubble appears.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      d_q        <= '0;
      d_valid_q  <= 1'b0;
      d_ch_q     <= '0;
      last_grant <= SELW'(NUM_CH - 1);
    end else if (load) begin
      d_q       <= grant_data;
      d_ch_q    <= grant_idx;
      d_valid_q <= 1'b1;
      if (MODE == 1) begin
        last_grant <= grant_idx;
      end
    end else if (bus.d_ready) begin
      d_valid_q <= 1'b0;
    end
  end

  assign bus.d       = d_q;
  assign bus.d_valid = d_valid_q;
  assign bus.d_ch    = d_ch_q;

endmodule
